// File: rtl/pipe_pkg.sv
// Shared control-word layout for the decode/execute pipeline stage.
// Field positions are fixed; the stage only decodes them for convenience.
package pipe_pkg;
  localparam int CTRL_WRE       = 7;
  localparam int CTRL_MEM_WE    = 6;
  localparam int CTRL_WB_SEL_HI = 5;
  localparam int CTRL_WB_SEL_LO = 4;
  localparam int CTRL_ALU_HI    = 3;
  localparam int CTRL_ALU_LO    = 0;

  typedef logic [7:0] ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register.
// Clear beats load on the valid bit; payload only changes on a load.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (clr_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
      end
      if (load_i && !clr_i) begin
        data_q <= d_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/decode_execute_stage.sv
// Decode->Execute register stage with valid/ready handshake, optional skid slot,
// synchronous flush and saturating stall/bubble counters.
module decode_execute_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int CTRL_W  = 8,
  parameter int NUM_SRC = 2,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [NUM_SRC*REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic                      out_wre,
  output logic                      out_mem_we,
  output logic [1:0]                out_wb_sel,
  output logic [3:0]                out_alu_op,
  output logic [NUM_SRC*DATA_W-1:0] out_src,
  output logic [NUM_SRC*REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0]         out_rd,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          bubble_cycles
);

  localparam int PW = CTRL_W + NUM_SRC * (DATA_W + REG_AW) + REG_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Handshake: a beat moves on a port in any cycle where valid and ready are
  // both high at the rising edge; valid never depends on ready on either side.
  logic          accept, transfer;
  logic          main_valid, main_load, main_clr;
  logic          skid_valid, skid_load, skid_clr;
  logic [PW-1:0] in_pay, main_d, main_q, skid_q;

  logic [CTRL_W-1:0]         main_ctrl;
  logic [NUM_SRC*DATA_W-1:0] main_src;
  logic [NUM_SRC*REG_AW-1:0] main_rs;
  logic [REG_AW-1:0]         main_rd;

  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  assign in_pay   = {in_ctrl, in_src, in_rs, in_rd};
  assign accept   = in_valid && in_ready;
  assign transfer = main_valid && out_ready;

  // Skid drains into main first; otherwise new input enters main when it frees up.
  assign main_load = !flush && ((transfer && skid_valid) ||
                                (accept && (!main_valid || transfer)));
  assign main_d    = skid_valid ? skid_q : in_pay;
  assign main_clr  = flush || (transfer && !main_load);
  assign skid_load = !flush && accept && main_valid && !transfer;
  assign skid_clr  = flush || (transfer && skid_valid);

  pipe_slot #(.W(PW)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (main_load),
    .clr_i  (main_clr),
    .d_i    (main_d),
    .valid_o(main_valid),
    .q_o    (main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(.W(PW)) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load_i (skid_load),
      .clr_i  (skid_clr),
      .d_i    (in_pay),
      .valid_o(skid_valid),
      .q_o    (skid_q)
    );
    assign in_ready = !skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_q     = '0;
    assign in_ready   = !main_valid || out_ready;
  end

  assign {main_ctrl, main_src, main_rs, main_rd} = main_q;

  assign out_valid  = main_valid;
  assign out_ctrl   = main_valid ? main_ctrl : CTRL_W'(CTRL_NOP);
  assign out_wre    = out_ctrl[CTRL_WRE];
  assign out_mem_we = out_ctrl[CTRL_MEM_WE];
  assign out_wb_sel = out_ctrl[CTRL_WB_SEL_HI:CTRL_WB_SEL_LO];
  assign out_alu_op = out_ctrl[CTRL_ALU_HI:CTRL_ALU_LO];
  assign out_src    = main_src;
  assign out_rs     = main_rs;
  assign out_rd     = main_rd;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (main_valid && !out_ready && stall_q != CNT_MAX) stall_d = stall_q + CNT_ONE;
      if (!main_valid && bubble_q != CNT_MAX) bubble_d = bubble_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: one SKID=1 and one SKID=0 instance
// share the input stimulus.
module tb_decode_execute_stage;
  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int CTRL_W  = 8;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, flush, out_ready, cnt_clr;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [NUM_SRC*DATA_W-1:0] in_src;
  logic [NUM_SRC*REG_AW-1:0] in_rs;
  logic [REG_AW-1:0]         in_rd;

  logic                      in_ready, out_valid, out_wre, out_mem_we;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [1:0]                out_wb_sel;
  logic [3:0]                out_alu_op;
  logic [NUM_SRC*DATA_W-1:0] out_src;
  logic [NUM_SRC*REG_AW-1:0] out_rs;
  logic [REG_AW-1:0]         out_rd;
  logic [CNT_W-1:0]          stall_cycles, bubble_cycles;

  logic                      o0_in_ready, o0_out_valid, o0_wre, o0_mem_we;
  logic [CTRL_W-1:0]         o0_ctrl;
  logic [1:0]                o0_wb_sel;
  logic [3:0]                o0_alu_op;
  logic [NUM_SRC*DATA_W-1:0] o0_src;
  logic [NUM_SRC*REG_AW-1:0] o0_rs;
  logic [REG_AW-1:0]         o0_rd;
  logic [CNT_W-1:0]          o0_stall, o0_bubble;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_execute_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W),
                         .NUM_SRC(NUM_SRC), .SKID(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_src(in_src), .in_rs(in_rs), .in_rd(in_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_wre(out_wre), .out_mem_we(out_mem_we),
    .out_wb_sel(out_wb_sel), .out_alu_op(out_alu_op), .out_src(out_src),
    .out_rs(out_rs), .out_rd(out_rd), .cnt_clr(cnt_clr),
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  decode_execute_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W),
                         .NUM_SRC(NUM_SRC), .SKID(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_ctrl(in_ctrl), .in_src(in_src), .in_rs(in_rs), .in_rd(in_rd),
    .flush(flush), .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_ctrl(o0_ctrl), .out_wre(o0_wre), .out_mem_we(o0_mem_we),
    .out_wb_sel(o0_wb_sel), .out_alu_op(o0_alu_op), .out_src(o0_src),
    .out_rs(o0_rs), .out_rd(o0_rd), .cnt_clr(cnt_clr),
    .stall_cycles(o0_stall), .bubble_cycles(o0_bubble)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_ctrl = '0; in_src = '0; in_rs = '0; in_rd = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_bubble", bubble_cycles, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Streaming at full rate
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h85; tick();
    chk("s1_valid", out_valid, 1);
    chk("s1_ctrl", out_ctrl, 8'h85);
    chk("s1_wre", out_wre, 1);
    chk("s1_alu", out_alu_op, 4'h5);
    chk("s1_in_ready", in_ready, 1);
    chk("s1_ctrl_sk0", o0_ctrl, 8'h85);
    in_ctrl = 8'h41; tick();
    chk("s2_ctrl", out_ctrl, 8'h41);
    chk("s2_mem_we", out_mem_we, 1);
    chk("s2_wre", out_wre, 0);
    chk("s2_ctrl_sk0", o0_ctrl, 8'h41);
    in_ctrl = 8'h12; tick();
    chk("s3_ctrl", out_ctrl, 8'h12);
    chk("s3_wb_sel", out_wb_sel, 2'd1);
    chk("s3_in_ready", in_ready, 1);
    in_ctrl = 8'h93; tick();
    chk("s4_ctrl", out_ctrl, 8'h93);
    chk("s4_alu", out_alu_op, 4'h3);
    chk("s4_ctrl_sk0", o0_ctrl, 8'h93);
    chk("s4_in_ready_sk0", o0_in_ready, 1);
    in_valid = 1'b0; tick();
    chk("s_drain_valid", out_valid, 0);
    chk("s_drain_ctrl", out_ctrl, 0);
    chk("s_bubble", bubble_cycles, 1);
    chk("s_stall", stall_cycles, 0);

    // Backpressure into the skid slot
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; tick();
    chk("bp_main_ctrl", out_ctrl, 8'h11);
    chk("bp_ready_1", in_ready, 1);
    in_ctrl = 8'h22; tick();
    chk("bp_ready_0", in_ready, 0);
    chk("bp_hold_ctrl", out_ctrl, 8'h11);
    in_ctrl = 8'h33; tick();
    chk("bp_third_held", out_ctrl, 8'h11);
    chk("bp_ready_still0", in_ready, 0);
    tick();
    chk("bp_stall3", stall_cycles, 3);
    out_ready = 1'b1; tick();
    chk("bp_order2", out_ctrl, 8'h22);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_order3", out_ctrl, 8'h33);
    in_valid = 1'b0; tick();
    chk("bp_drained", out_valid, 0);
    chk("bp_stall_final", stall_cycles, 3);

    // Flush with both slots full and an incoming 0xFF
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h44; tick();
    in_ctrl = 8'h55; tick();
    chk("fl_full", in_ready, 0);
    flush = 1'b1; in_ctrl = 8'hFF; tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_wre", out_wre, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("fl_no_ff", out_valid, 0);
    in_valid = 1'b1; flush = 1'b1; tick();
    chk("fl_drop_empty", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;

    // Payload integrity and hold under stall
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h85;
    in_src = 32'hBEEF_1234; in_rs = 8'h39; in_rd = 4'd12; tick();
    in_valid = 1'b0; in_src = '0; in_rs = '0; in_rd = '0;
    chk("pl_src", out_src, 32'hBEEF_1234);
    chk("pl_rs", out_rs, 8'h39);
    chk("pl_rd", out_rd, 4'd12);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pl_hold_src", out_src, 32'hBEEF_1234);
      chk("pl_hold_ctrl", out_ctrl, 8'h85);
    end

    // Stall counter saturation and clear
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat_clr0", stall_cycles, 0);
    repeat (65534) tick();
    chk("sat_fffe", stall_cycles, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cycles, 16'hFFFF);
    repeat (3) tick();
    chk("sat_hold", stall_cycles, 16'hFFFF);
    chk("sat_bubble0", bubble_cycles, 0);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat_clr", stall_cycles, 0);
    tick();
    chk("sat_restart", stall_cycles, 1);

    // Asynchronous reset while full and stalled
    in_valid = 1'b1; in_ctrl = 8'h66; tick();
    in_valid = 1'b0;
    chk("ar_full", in_ready, 0);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_src", out_src, 0);
    chk("ar_stall", stall_cycles, 0);
    #1 reset = 1'b1;

    // Single-register variant: combinational in_ready
    out_ready = 1'b0; #1;
    chk("sk0_ready_empty", o0_in_ready, 1);
    in_valid = 1'b1; in_ctrl = 8'h85; tick();
    chk("sk0_load", o0_ctrl, 8'h85);
    chk("sk0_ready_full", o0_in_ready, 0);
    in_ctrl = 8'h77; tick();
    chk("sk0_not_accepted", o0_ctrl, 8'h85);
    out_ready = 1'b1; #1;
    chk("sk0_ready_comb", o0_in_ready, 1);
    in_ctrl = 8'h41; tick();
    chk("sk0_s2", o0_ctrl, 8'h41);
    in_ctrl = 8'h12; tick();
    chk("sk0_s3", o0_ctrl, 8'h12);
    in_ctrl = 8'h93; tick();
    chk("sk0_s4", o0_ctrl, 8'h93);
    in_valid = 1'b0; tick();
    chk("sk0_drain", o0_out_valid, 0);
    chk("sk0_drain_ctrl", o0_ctrl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_stage.md
Name: decode_execute_stage

Overview:
- Parametrised Decode→Execute pipeline stage with valid/ready handshake, an optional 2-entry skid buffer, synchronous flush and saturating stall/bubble counters.
- Carries the packed control word, NUM_SRC operand values, source register indices and destination index from decode to execute.
- Invalid or flushed slots present an all-zero control word (NOP), so no write enable can leak downstream.

Parameters:
DATA_W, 16, operand width
REG_AW, 4, register index width
CTRL_W, 8, control word width (field layout in pipe_pkg)
NUM_SRC, 2, number of source operands
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (in_ready combinational)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept
in_ctrl  in  CTRL_W  packed control word from the NOP mux
in_src  in  NUM_SRC*DATA_W  operand values, src0 in LSBs
in_rs  in  NUM_SRC*REG_AW  source indices, rs0 in LSBs
in_rd  in  REG_AW  destination index
flush  in  1  kill all held and incoming instructions
out_valid  out  1  execute-side instruction valid
out_ready  in  1  execute consumes
out_ctrl  out  CTRL_W  control word; zero when !out_valid
out_wre, out_mem_we  out  1 each  decoded from out_ctrl
out_wb_sel  out  2  decoded from out_ctrl
out_alu_op  out  4  decoded from out_ctrl
out_src  out  NUM_SRC*DATA_W  operands
out_rs  out  NUM_SRC*REG_AW  source indices (forwarding unit)
out_rd  out  REG_AW  destination index
cnt_clr  in  1  synchronous clear of both counters
stall_cycles  out  CNT_W  cycles with out_valid && !out_ready
bubble_cycles  out  CNT_W  cycles with !out_valid

Behaviour:
- Reset (reset=0, async): main_valid=0, skid_valid=0, all payload registers=0, counters=0.
  - Visible outputs: out_valid=0, out_ctrl=0, in_ready=1 (SKID=1).
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput: 1 instruction/cycle while out_ready=1.
- SKID=1:
  - in_ready = !skid_valid, registered.
  - Accept while main is empty, or while main is transferring → load main.
  - Accept while main is full and not transferring → load skid.
  - Transfer with skid_valid → skid moves to main; skid clears unless a same-cycle accept refills it.
- SKID=0:
  - in_ready = !main_valid || out_ready.
  - Accept loads main; transfer without accept clears main_valid.
- Payload registers load only on accept; they hold otherwise. Never clear them on drain.
- Flush (synchronous, highest priority): next cycle main_valid=0 and skid_valid=0. An input presented in the same cycle is dropped even if in_ready=1. Flush concurrent with a transfer: the transfer completes and the downstream edge sees it.
- out_ctrl = main_valid ? main_ctrl : 0. The decoded field outputs follow out_ctrl.
- Ordering is strictly FIFO. No instruction is duplicated or lost except through flush.
- Counters:
  - Increment once per cycle on their condition.
  - Saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr wins over increment.
  - Counters are not affected by flush.
- Reset mid-operation discards all held instructions immediately.

Decomposition:
- pipe_pkg holds:
  - Control field constants: CTRL_WRE=7, CTRL_MEM_WE=6, CTRL_WB_SEL_HI/LO=5/4, CTRL_ALU_HI/LO=3/0.
  - typedef ctrl_t (logic [7:0]).
  - CTRL_NOP='0.
- One sub-module, pipe_slot: one valid bit plus payload register with load/clear. Instantiate it twice (main, skid); instantiate the skid only when SKID=1.

Test Plan:
- Reset, then stream 4 instructions with out_ctrl 0x85/0x41/0x12/0x93 and out_ready=1 → each appears 1 cycle later in order; in_ready stays 1; bubble_cycles counts only the initial empty cycles.
- Hold out_ready=0 and present 3 instructions (SKID=1) → first two accepted (main, skid); in_ready drops to 0 the next cycle; third is held. Release out_ready → order 1,2,3 and stall_cycles = number of stalled cycles.
- Main and skid full, then flush=1 with in_valid=1 and ctrl=0xFF → next cycle out_valid=0, out_ctrl=0x00, out_wre=0, in_ready=1; the 0xFF instruction never appears.
- in_src={0xBEEF,0x1234}, in_rs={3,9}, in_rd=12 → out_src, out_rs and out_rd match exactly. Outputs remain stable through 5 stall cycles.
- Preload stall_cycles near 0xFFFF through a long stall, then continue stalling → holds at 0xFFFF. Assert cnt_clr during the stall → 0 next cycle.
- Assert reset=0 asynchronously while full and stalled → out_valid=0 and out_ctrl=0 before the next clk edge. Repeat the streaming test with SKID=0: verify in_ready = !main_valid || out_ready combinationally.
